divider_seq: RTL
================

Name: divider_seq

Overview:
- Sequential radix-2 restoring divider; the inverse companion of the multi-cycle Booth multiplier.
- Computes quotient and remainder of a WIDTH_N dividend by a WIDTH_D divisor, one quotient bit per cycle.
- Used for normalisation/scaling of systolic-array accumulator outputs.
- Same APPROX_TYPE / APPROX_W / SIGNED parameter conventions as the multiplier; adds a valid/ready handshake.

Parameters:
- WIDTH_N, 32, dividend and quotient width (matches multiplier WIDTH_MUL).
- WIDTH_D, 16, divisor and remainder width; must satisfy WIDTH_D <= WIDTH_N.
- SIGNED, 0, 1 = two's-complement operands with truncate-toward-zero semantics.
- APPROX_TYPE, 0, 1 = approximate mode: run only WIDTH_N-APPROX_W iterations.
- APPROX_W, 16, number of low quotient bits forced to zero in approximate mode; must be < WIDTH_N.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider idle, can accept.
- N  in  WIDTH_N  dividend.
- D  in  WIDTH_D  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Q  out  WIDTH_N  quotient.
- R  out  WIDTH_D  remainder.
- dbz  out  1  divide-by-zero flag, qualified by out_valid.

Behaviour:
- Reset, asynchronous with rst_n low: state IDLE; in_ready=1; out_valid=0; Q=0; R=0; dbz=0; all internal registers 0.
- Reset mid-operation aborts the division with no output.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register operand magnitudes, result signs and iteration counter.
  - D==0 goes to DONE; otherwise goes to CALC.
  - Operands are sampled only at acceptance.
- CALC:
  - Each cycle: rem = {rem, next dividend bit MSB-first}; if rem >= |D|, subtract and shift in quotient bit 1, else shift in 0.
  - Iteration count is ITER = WIDTH_N when APPROX_TYPE=0, else ITER = WIDTH_N-APPROX_W.
  - After ITER cycles, go to FIX.
- FIX (1 cycle):
  - Apply signs when SIGNED: Q negated if sign(N)^sign(D); R negated if sign(N).
  - Approximate mode: left-shift Q by APPROX_W (low bits zero) and force R=0.
  - Load output registers; go to DONE.
- DONE:
  - out_valid=1; Q/R/dbz held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE and clear out_valid the next cycle.
  - in_ready=0 in CALC, FIX and DONE; no pipelining and no simultaneous accept/retire.
- Latency:
  - Normal: acceptance edge at cycle k; out_valid high from k+ITER+2.
  - D==0: out_valid high from k+1.
- Width rules:
  - Magnitudes are unsigned WIDTH_N / WIDTH_D; partial remainder is WIDTH_D+1 bits.
  - |N|=2^(WIDTH_N-1) is representable in the unsigned magnitude.
- Divide-by-zero: dbz=1, Q=all ones, R=N[WIDTH_D-1:0].
- Signed overflow (SIGNED=1, N=MIN, D=-1): Q wraps to MIN, R=0, dbz=0.
- Unsigned mode ignores operand sign bits entirely.

Optional Feature:
- Macro: DIVIDER_SAT_EN.
- Defined:
  - Divide-by-zero with SIGNED=1 gives Q = N>=0 ? max positive : min negative.
  - Signed MIN/-1 gives Q = max positive.
  - R follows the default rules above.
- Undefined: the default wrap / all-ones behaviour above applies.
- The unsigned path is identical either way.

Decomposition:
- Package divider_pkg holds:
  - state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3);
  - max macro/function;
  - function iter_count(WIDTH_N, APPROX_TYPE, APPROX_W);
  - counter width constant $clog2(WIDTH_N+1).
- One natural sub-module, divider_sign_cond: combinational abs/sign extraction and result negation, instantiated for input conditioning and reused in FIX.

Test Plan (WIDTH_N=32, WIDTH_D=16):
- Unsigned N=1000, D=7 -> Q=142, R=6, dbz=0; out_valid exactly 34 cycles after the accept edge; in_ready=0 throughout.
- SIGNED=1, N=-7, D=2 -> Q=0xFFFFFFFD, R=0xFFFF. Also N=7, D=-2 -> Q=0xFFFFFFFD, R=0x0001.
- Divide-by-zero N=5, D=0 -> out_valid next cycle, dbz=1, Q=0xFFFFFFFF, R=0x0005. With DIVIDER_SAT_EN, SIGNED=1, N=-5 -> Q=0x80000000.
- SIGNED=1, N=0x80000000, D=0xFFFF -> Q=0x80000000, R=0. With DIVIDER_SAT_EN -> Q=0x7FFFFFFF.
- Backpressure: hold out_ready=0 for 10 cycles after result -> Q/R stable, out_valid high, in_valid ignored. Release -> in_ready=1 next cycle.
- Reset mid-CALC (cycle 10), then APPROX_TYPE=1, APPROX_W=8, N=100000, D=3:
  - Reset -> out_valid never pulses; outputs 0.
  - Approximate op -> Q=0x00008200, R=0; out_valid 26 cycles after accept.

Source files
------------

// File: rtl/divider_pkg.sv
// ============================================================================
// Module      : divider_pkg
// Description : Shared types and helpers for the sequential restoring divider.
//               Provides the FSM state encoding, a max helper, the
//               iteration-count helper for exact/approximate modes and the
//               iteration counter width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Approximate mode skips the APPROX_W low quotient bits entirely.
   function automatic int iter_count(input int wn, input int approx_type, input int approx_w);
      return (approx_type != 0) ? (wn - approx_w) : wn;
   endfunction

   // Counter must be able to hold the full iteration count WIDTH_N.
   function automatic int cnt_width(input int wn);
      return max_i($clog2(wn + 1), 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/divider_sign_cond.sv
// ============================================================================
// Module      : divider_sign_cond
// Description : Combinational sign handling for the divider. Extracts the
//               two's-complement sign of an operand (only when SIGNED != 0)
//               and either takes the magnitude (abs_i=1) or conditionally
//               negates the value (abs_i=0, neg_i selects negation).
// Ports       : val_i  [W-1:0] operand / result value
//               abs_i           1 = produce |val_i| using its own sign
//               neg_i           negate request when abs_i = 0
//               sign_o          sign bit of val_i (0 in unsigned mode)
//               res_o  [W-1:0] magnitude or conditionally negated value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_sign_cond #(
   parameter int W      = 32,
   parameter int SIGNED = 0
) (
   input  logic [W-1:0] val_i,
   input  logic         abs_i,
   input  logic         neg_i,
   output logic         sign_o,
   output logic [W-1:0] res_o
);

   logic w_neg;

   // Unsigned operation ignores the top bit entirely.
   assign sign_o = (SIGNED != 0) ? val_i[W-1] : 1'b0;
   assign w_neg  = abs_i ? sign_o : neg_i;
   // The most negative value maps onto itself, which is exactly its
   // unsigned magnitude 2^(W-1).
   assign res_o  = w_neg ? ((~val_i) + W'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/divider_seq.sv
// ============================================================================
// Module      : divider_seq
// Description : Sequential radix-2 restoring divider, one quotient bit per
//               cycle, valid/ready handshake on both sides. Optional
//               saturation of divide-by-zero and signed MIN/-1 overflow is
//               enabled by defining the macro DIVIDER_SAT_EN.
// Ports       : clk, rst_n (async, active low)
//               in_valid / in_ready    operand handshake
//               N [WIDTH_N-1:0]        dividend
//               D [WIDTH_D-1:0]        divisor
//               out_valid / out_ready  result handshake
//               Q [WIDTH_N-1:0]        quotient
//               R [WIDTH_D-1:0]        remainder
//               dbz                    divide-by-zero, qualified by out_valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_seq
   import divider_pkg::*;
#(
   parameter int WIDTH_N     = 32,
   parameter int WIDTH_D     = 16,
   parameter int SIGNED      = 0,
   parameter int APPROX_TYPE = 0,
   parameter int APPROX_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_N-1:0] N,
   input  logic [WIDTH_D-1:0] D,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_N-1:0] Q,
   output logic [WIDTH_D-1:0] R,
   output logic               dbz
);

   localparam int               ITER   = iter_count(WIDTH_N, APPROX_TYPE, APPROX_W);
   localparam int               CNT_W  = cnt_width(WIDTH_N);
   localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);
`ifdef DIVIDER_SAT_EN
   localparam logic [WIDTH_N-1:0] Q_MAXP = {1'b0, {(WIDTH_N-1){1'b1}}};
   localparam logic [WIDTH_N-1:0] Q_MINN = {1'b1, {(WIDTH_N-1){1'b0}}};
`endif

   div_state_e state_q, state_d;

   logic [WIDTH_N-1:0] dvd_q,  dvd_d;    // dividend magnitude, consumed MSB-first
   logic [WIDTH_N-1:0] quo_q,  quo_d;    // quotient magnitude being built
   logic [WIDTH_D-1:0] rem_q,  rem_d;    // partial remainder (always < |D|)
   logic [WIDTH_D-1:0] dmag_q, dmag_d;   // divisor magnitude
   logic [CNT_W-1:0]   cnt_q,  cnt_d;
   logic               sgnq_q, sgnq_d;   // quotient must be negated
   logic               sgnr_q, sgnr_d;   // remainder must be negated
   logic [WIDTH_N-1:0] q_q,    q_d;
   logic [WIDTH_D-1:0] r_q,    r_d;
   logic               dbz_q,  dbz_d;

   logic               w_accept;
   logic               w_dzero;
   logic               w_sn, w_sd;
   logic [WIDTH_N-1:0] w_nmag;
   logic [WIDTH_D-1:0] w_dmag;
   logic [WIDTH_D:0]   w_rem_sh;
   logic [WIDTH_D:0]   w_dext;
   logic [WIDTH_D:0]   w_diff;
   logic               w_sub_ok;
   logic [WIDTH_N-1:0] w_q_mag;
   logic [WIDTH_N-1:0] w_q_neg;
   logic               w_q_msb;
   logic [WIDTH_N-1:0] w_q_fix;
   logic [WIDTH_D-1:0] w_r_fix;
   logic [WIDTH_N-1:0] w_dbz_q;
   logic [1:0]         w_unused;

   // ------------------------------------------------------------------
   // Operand conditioning and result sign application
   // ------------------------------------------------------------------
   divider_sign_cond #(.W(WIDTH_N), .SIGNED(SIGNED)) u_abs_n (
      .val_i  (N),
      .abs_i  (1'b1),
      .neg_i  (1'b0),
      .sign_o (w_sn),
      .res_o  (w_nmag)
   );

   divider_sign_cond #(.W(WIDTH_D), .SIGNED(SIGNED)) u_abs_d (
      .val_i  (D),
      .abs_i  (1'b1),
      .neg_i  (1'b0),
      .sign_o (w_sd),
      .res_o  (w_dmag)
   );

   // sign_o here is the MSB of the quotient magnitude in signed mode; a set
   // MSB with a positive result sign is the MIN/-1 overflow case.
   divider_sign_cond #(.W(WIDTH_N), .SIGNED(SIGNED)) u_neg_q (
      .val_i  (w_q_mag),
      .abs_i  (1'b0),
      .neg_i  (sgnq_q),
      .sign_o (w_q_msb),
      .res_o  (w_q_neg)
   );

   assign w_accept = in_valid && (state_q == S_IDLE);
   assign w_dzero  = (D == '0);

   // ------------------------------------------------------------------
   // Restoring step
   // ------------------------------------------------------------------
   assign w_rem_sh = {rem_q, dvd_q[WIDTH_N-1]};
   assign w_dext   = {1'b0, dmag_q};
   assign w_sub_ok = (w_rem_sh >= w_dext);
   assign w_diff   = w_rem_sh - w_dext;

   // After a successful subtract the result is below |D|, so its MSB is
   // always zero; the sign bit of the quotient is only needed when
   // saturation is compiled in.
   assign w_unused = {w_diff[WIDTH_D], w_q_msb};

   // ------------------------------------------------------------------
   // Result fix-up
   // ------------------------------------------------------------------
   always_comb begin
      w_q_mag = quo_q;
      if (APPROX_TYPE != 0) begin
         w_q_mag = quo_q << APPROX_W;
      end
   end

   always_comb begin
      w_q_fix = w_q_neg;
`ifdef DIVIDER_SAT_EN
      if (!sgnq_q && w_q_msb) begin
         w_q_fix = Q_MAXP;
      end
`endif
   end

   always_comb begin
      w_r_fix = sgnr_q ? ((~rem_q) + WIDTH_D'(1)) : rem_q;
      if (APPROX_TYPE != 0) begin
         w_r_fix = '0;
      end
   end

   always_comb begin
      w_dbz_q = '1;
`ifdef DIVIDER_SAT_EN
      if (SIGNED != 0) begin
         w_dbz_q = N[WIDTH_N-1] ? Q_MINN : Q_MAXP;
      end
`endif
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (w_accept) state_d = w_dzero ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_comb begin
      dvd_d  = dvd_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dmag_d = dmag_q;
      cnt_d  = cnt_q;
      sgnq_d = sgnq_q;
      sgnr_d = sgnr_q;
      q_d    = q_q;
      r_d    = r_q;
      dbz_d  = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               dvd_d  = w_nmag;
               dmag_d = w_dmag;
               quo_d  = '0;
               rem_d  = '0;
               cnt_d  = ITER_C;
               sgnq_d = w_sn ^ w_sd;
               sgnr_d = w_sn;
               dbz_d  = w_dzero;
               if (w_dzero) begin
                  q_d = w_dbz_q;
                  r_d = N[WIDTH_D-1:0];
               end
            end
         end
         S_CALC: begin
            rem_d = w_sub_ok ? w_diff[WIDTH_D-1:0] : w_rem_sh[WIDTH_D-1:0];
            quo_d = {quo_q[WIDTH_N-2:0], w_sub_ok};
            dvd_d = {dvd_q[WIDTH_N-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
         end
         S_FIX: begin
            q_d   = w_q_fix;
            r_d   = w_r_fix;
            dbz_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dmag_q <= '0;
         cnt_q  <= '0;
         sgnq_q <= 1'b0;
         sgnr_q <= 1'b0;
         q_q    <= '0;
         r_q    <= '0;
         dbz_q  <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dmag_q <= dmag_d;
         cnt_q  <= cnt_d;
         sgnq_q <= sgnq_d;
         sgnr_q <= sgnr_d;
         q_q    <= q_d;
         r_q    <= r_d;
         dbz_q  <= dbz_d;
      end
   end

   assign Q   = q_q;
   assign R   = r_q;
   assign dbz = dbz_q;

endmodule

`default_nettype wire
